sw_input_conditioner: RTL and testbench



---
 rtl/sw_input_conditioner_pkg.sv | 13 +
 rtl/sw_debounce_bit.sv | 53 +++++
 rtl/sw_input_conditioner.sv | 77 +++++++
 tb/tb_sw_input_conditioner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sw_input_conditioner_pkg.sv
// Shared defaults and sizing helpers for the switch input conditioner.
package sw_input_conditioner_pkg;

  localparam int unsigned DEF_WIDTH        = 4;
  localparam int unsigned DEF_TICK_DIV     = 11;
  localparam int unsigned DEF_STABLE_TICKS = 3;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, tick-driven stability counter, edge pulses.
module sw_debounce_bit
  import sw_input_conditioner_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic upd
);

  localparam int unsigned CNT_W = cnt_width(STABLE_TICKS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

  logic             sw_meta;
  logic             sw_sync;
  logic [CNT_W-1:0] stab_cnt;

  // High on the clk edge at which clean takes the synchronised value.
  assign upd = tick && (sw_sync != clean) && (stab_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta  <= 1'b0;
      sw_sync  <= 1'b0;
      stab_cnt <= '0;
      clean    <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      rise    <= upd & sw_sync;
      fall    <= upd & ~sw_sync;
      if (tick) begin
        if (sw_sync == clean) begin
          stab_cnt <= '0;
        end else if (stab_cnt == LAST) begin
          clean    <= sw_sync;
          stab_cnt <= '0;
        end else begin
          stab_cnt <= stab_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sw_input_conditioner.sv
// Debounced switch vector with edge pulses and a coalescing valid/ready change-event channel.
module sw_input_conditioner
  import sw_input_conditioner_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             all_off,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_data,
  output logic             evt_overrun,
  input  logic             evt_ready
);

  localparam int unsigned TC_W = cnt_width(TICK_DIV);

  logic [TC_W-1:0]  tick_cnt;
  logic             tick;
  logic [WIDTH-1:0] upd;
  logic             change;
  logic             accept;

  assign tick = (tick_cnt == TC_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TC_W'(1);
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .sw    (sw[b]),
      .clean (sw_clean[b]),
      .rise  (sw_rise[b]),
      .fall  (sw_fall[b]),
      .upd   (upd[b])
    );
  end

  assign all_off = ~|sw_clean;
  assign change  = |upd;
  assign accept  = evt_valid & evt_ready;

  // A change landing on an unaccepted event replaces its data and flags the loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid   <= 1'b0;
      evt_data    <= '0;
      evt_overrun <= 1'b0;
    end else if (change) begin
      evt_valid   <= 1'b1;
      evt_data    <= sw_clean ^ upd;
      evt_overrun <= evt_valid & ~evt_ready;
    end else if (accept) begin
      evt_valid   <= 1'b0;
      evt_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Drives two conditioner instances (TICK_DIV=4 and TICK_DIV=1) against a window-based reference model.
module tb_sw_input_conditioner;

  localparam int unsigned W = 4;
  localparam int unsigned S = 3;

  logic clk;
  logic rst_n;
  logic [W-1:0] sw_in;
  logic rdy;

  logic [1:0][W-1:0] clean_o, rise_o, fall_o, data_o;
  logic [1:0]        all_off_o, valid_o, ovr_o;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  sw_input_conditioner #(.WIDTH(W), .TICK_DIV(4), .STABLE_TICKS(S)) dut0 (
    .clk(clk), .rst_n(rst_n), .sw(sw_in),
    .sw_clean(clean_o[0]), .sw_rise(rise_o[0]), .sw_fall(fall_o[0]),
    .all_off(all_off_o[0]), .evt_valid(valid_o[0]), .evt_data(data_o[0]),
    .evt_overrun(ovr_o[0]), .evt_ready(rdy)
  );

  sw_input_conditioner #(.WIDTH(W), .TICK_DIV(1), .STABLE_TICKS(S)) dut1 (
    .clk(clk), .rst_n(rst_n), .sw(sw_in),
    .sw_clean(clean_o[1]), .sw_rise(rise_o[1]), .sw_fall(fall_o[1]),
    .all_off(all_off_o[1]), .evt_valid(valid_o[1]), .evt_data(data_o[1]),
    .evt_overrun(ovr_o[1]), .evt_ready(rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: clean flips a bit when the last S tick samples all disagree with it.
  logic [W-1:0]  m_clean [2];
  logic [W-1:0]  m_rise  [2];
  logic [W-1:0]  m_fall  [2];
  logic [W-1:0]  m_data  [2];
  logic          m_valid [2];
  logic          m_ovr   [2];
  logic [W-1:0]  dly     [2][2];
  logic [W-1:0]  hist    [2][S];
  int unsigned   nh      [2];
  int unsigned   kc      [2];

  function automatic int unsigned div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_clean[i] = '0; m_rise[i] = '0; m_fall[i] = '0; m_data[i] = '0;
      m_valid[i] = 1'b0; m_ovr[i] = 1'b0; nh[i] = 0; kc[i] = 0;
      dly[i][0] = '0; dly[i][1] = '0;
      for (int j = 0; j < int'(S); j++) hist[i][j] = '0;
    end
  endtask

  function automatic logic [W-1:0] upd_mask(input int i);
    logic [W-1:0] m;
    if (((kc[i] + 1) % div_of(i)) != 0) return '0;
    if (nh[i] + 1 < S) return '0;
    m = dly[i][1] ^ m_clean[i];
    for (int j = 0; j < int'(S) - 1; j++) m &= hist[i][j] ^ m_clean[i];
    return m;
  endfunction

  task automatic model_step(input int i, input logic [W-1:0] p, input logic r);
    logic [W-1:0] u;
    logic         was_valid;
    u = upd_mask(i);
    if (((kc[i] + 1) % div_of(i)) == 0) begin
      for (int j = int'(S) - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = dly[i][1];
      if (nh[i] < S) nh[i]++;
    end
    dly[i][1] = dly[i][0];
    dly[i][0] = p;
    kc[i]++;
    m_clean[i] = m_clean[i] ^ u;
    m_rise[i]  = u & m_clean[i];
    m_fall[i]  = u & ~m_clean[i];
    was_valid  = m_valid[i];
    if (u != '0) begin
      m_ovr[i]   = was_valid & ~r;
      m_valid[i] = 1'b1;
      m_data[i]  = m_clean[i];
    end else if (was_valid && r) begin
      m_valid[i] = 1'b0;
      m_ovr[i]   = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("sw_clean",    i, 32'(clean_o[i]),   32'(m_clean[i]));
      chk("sw_rise",     i, 32'(rise_o[i]),    32'(m_rise[i]));
      chk("sw_fall",     i, 32'(fall_o[i]),    32'(m_fall[i]));
      chk("all_off",     i, 32'(all_off_o[i]), 32'(m_clean[i] == '0));
      chk("evt_valid",   i, 32'(valid_o[i]),   32'(m_valid[i]));
      chk("evt_data",    i, 32'(data_o[i]),    32'(m_data[i]));
      chk("evt_overrun", i, 32'(ovr_o[i]),     32'(m_ovr[i]));
    end
  endtask

  task automatic check_reset_consts(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_clean"}, i, 32'(clean_o[i]), 32'd0);
      chk({tag, "_edges"}, i, 32'(rise_o[i] | fall_o[i]), 32'd0);
      chk({tag, "_alloff"}, i, 32'(all_off_o[i]), 32'd1);
      chk({tag, "_evt"}, i, 32'({valid_o[i], data_o[i], ovr_o[i]}), 32'd0);
    end
  endtask

  task automatic cycle(input logic [W-1:0] s, input logic r);
    sw_in = s;
    rdy   = r;
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 2; i++) model_step(i, s, r);
    end else begin
      model_reset();
    end
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    int unsigned lat0, lat1, n, cnt;
    logic [W-1:0] u;
    logic hit;

    rst_n = 1'b0; sw_in = '0; rdy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_consts("reset");
    rst_n = 1'b1;

    // 1: single bit on; latency window for both prescaler settings
    lat0 = 0; lat1 = 0; cnt = 0;
    for (n = 1; n <= 30; n++) begin
      cycle(4'b0001, 1'b0);
      if (rise_o[0] == 4'b0001) cnt++;
      if (lat0 == 0 && clean_o[0] == 4'b0001) lat0 = n;
      if (lat1 == 0 && clean_o[1] == 4'b0001) lat1 = n;
    end
    chk("s1_lat_min", 0, 32'(lat0 >= 11), 32'd1);
    chk("s1_lat_max", 0, 32'(lat0 <= 14), 32'd1);
    chk("s1_lat_div1", 1, 32'(lat1), 32'd5);
    chk("s1_rise_once", 0, 32'(cnt), 32'd1);
    chk("s1_evt", 0, 32'({valid_o[0], data_o[0], all_off_o[0]}), 32'b1_0001_0);

    // 2: two-tick glitch on bit 1 must be filtered
    cycle(4'b0001, 1'b1);
    repeat (8) begin
      cycle(4'b0011, 1'b0);
      chk("s2_clean", 0, 32'(clean_o[0]), 32'd1);
      chk("s2_quiet", 0, 32'({valid_o[0], rise_o[0]}), 32'd0);
    end
    repeat (20) begin
      cycle(4'b0001, 1'b0);
      chk("s2_clean", 0, 32'(clean_o[0]), 32'd1);
      chk("s2_quiet", 0, 32'({valid_o[0], rise_o[0]}), 32'd0);
    end

    // 3: coalescing while ready is low, then accept
    repeat (20) cycle(4'b0011, 1'b0);
    repeat (20) cycle(4'b0111, 1'b0);
    chk("s3_pending", 0, 32'({valid_o[0], data_o[0], ovr_o[0]}), 32'b1_0111_1);
    cycle(4'b0111, 1'b1);
    chk("s3_accepted", 0, 32'({valid_o[0], ovr_o[0]}), 32'd0);

    // 4: accept coinciding with a new change on a pending event
    repeat (20) cycle(4'b1111, 1'b0);
    repeat (20) cycle(4'b0111, 1'b0);
    hit = 1'b0;
    for (n = 0; n < 30 && !hit; n++) begin
      u = upd_mask(0);
      cycle(4'b0110, u != '0);
      if (u != '0) begin
        hit = 1'b1;
        chk("s4_evt", 0, 32'({valid_o[0], data_o[0], ovr_o[0]}), 32'b1_0110_0);
        chk("s4_fall", 0, 32'(fall_o[0]), 32'b0001);
      end
    end
    chk("s4_reached", 0, 32'(hit), 32'd1);
    cycle(4'b0110, 1'b0);

    // 5: asynchronous reset mid-count with an event pending
    repeat (20) cycle(4'b0110, 1'b0);
    sw_in = 4'b0110;
    repeat (3) cycle(4'b0100, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_consts("s5_async");
    @(negedge clk);
    repeat (2) cycle(4'b0110, 1'b0);
    rst_n = 1'b1;
    hit = 1'b0;
    for (n = 0; n < 30 && !hit; n++) begin
      cycle(4'b0110, 1'b0);
      if (valid_o[0]) hit = 1'b1;
    end
    chk("s5_event", 0, 32'({hit, data_o[0]}), 32'b1_0110);

    // 6: all switches off
    cycle(4'b0110, 1'b1);
    cnt = 0;
    for (n = 0; n < 25; n++) begin
      cycle(4'b0000, 1'b0);
      if (fall_o[0] == 4'b0110) cnt++;
    end
    chk("s6_fall_once", 0, 32'(cnt), 32'd1);
    chk("s6_off", 0, 32'({all_off_o[0], valid_o[0], data_o[0]}), 32'b1_1_0000);

    // random segments with random ready
    repeat (30) begin
      u = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 25)) cycle(u, 1'($urandom % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
